// File: rtl/flag_cond_unit_pkg.sv
// Shared definitions for the flag/condition unit: LEGv8 condition codes,
// NZCV bit positions and the request FSM state encoding.
package flag_cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_HS = 4'd2;
    localparam logic [3:0] COND_LO = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[NZCV_N] = n;
        f[NZCV_Z] = z;
        f[NZCV_C] = c;
        f[NZCV_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational LEGv8 B.cond evaluator: decides whether a condition code
// holds for a given {N,Z,C,V} flag vector.
module cond_eval
    import flag_cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;

    assign n_f = nzcv[NZCV_N];
    assign z_f = nzcv[NZCV_Z];
    assign c_f = nzcv[NZCV_C];
    assign v_f = nzcv[NZCV_V];

    // Condition-code decode; AL and NV are both unconditional in LEGv8.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z_f;
            COND_NE: taken = ~z_f;
            COND_HS: taken = c_f;
            COND_LO: taken = ~c_f;
            COND_MI: taken = n_f;
            COND_PL: taken = ~n_f;
            COND_VS: taken = v_f;
            COND_VC: taken = ~v_f;
            COND_HI: taken = c_f & ~z_f;
            COND_LS: taken = ~c_f | z_f;
            COND_GE: taken = (n_f == v_f);
            COND_LT: taken = (n_f != v_f);
            COND_GT: taken = ~z_f & (n_f == v_f);
            COND_LE: taken = z_f | (n_f != v_f);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural NZCV register, in-flight flag-setter tracking and B.cond
// request/response handshake. Define FLAG_FWD_EN to bypass ALU flags.
module flag_cond_unit
    import flag_cond_unit_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       fset_issue,
    input  logic       flag_wr,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       req_vld,
    output logic       req_rdy,
    input  logic [3:0] req_cond,
    output logic       rsp_vld,
    input  logic       rsp_rdy,
    output logic       rsp_taken,
    output logic [3:0] nzcv,
    output logic       pend_err
);

    localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);

    logic [3:0]        nzcv_q,  nzcv_d;
    logic [PEND_W-1:0] cnt_q,   cnt_d;
    logic              err_q,   err_d;
    state_e            state_q, state_d;
    logic [3:0]        cond_q,  cond_d;
    logic              taken_q, taken_d;

    logic [3:0] alu_flags;
    logic [3:0] eval_flags;
    logic [3:0] eval_cond;
    logic       eval_taken;
    logic       fwd_hit;
    logic       cnt_zero;

    assign alu_flags = pack_nzcv(alu_n, alu_z, alu_c, alu_v);
    assign cnt_zero  = (cnt_q == CNT_ZERO);

`ifdef FLAG_FWD_EN
    // The last outstanding flag-setter retires this cycle: its flags are final.
    assign fwd_hit = (cnt_q == CNT_ONE) && flag_wr && !fset_issue;
`else
    assign fwd_hit = 1'b0;
`endif

    assign eval_flags = fwd_hit ? alu_flags : nzcv_q;
    assign eval_cond  = (state_q == ST_IDLE) ? req_cond : cond_q;

    cond_eval u_cond_eval (
        .cond  (eval_cond),
        .nzcv  (eval_flags),
        .taken (eval_taken)
    );

    // Flag register next state: latch on every ALU flag write, flush included.
    always_comb begin
        nzcv_d = nzcv_q;
        if (flag_wr) begin
            nzcv_d = alu_flags;
        end else begin
            nzcv_d = nzcv_q;
        end
    end

    // Pending counter: saturates at both ends and records the misuse stickily.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (flush) begin
            cnt_d = CNT_ZERO;
        end else if (fset_issue && !flag_wr) begin
            if (cnt_q == CNT_MAX) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (flag_wr && !fset_issue) begin
            if (cnt_zero) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Request FSM next state; the result is captured once and held in RESP.
    always_comb begin
        state_d = state_q;
        cond_d  = cond_q;
        taken_d = taken_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (req_vld) begin
                    cond_d = req_cond;
                    if (cnt_zero || fwd_hit) begin
                        state_d = ST_RESP;
                        taken_d = eval_taken;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero || fwd_hit) begin
                    state_d = ST_RESP;
                    taken_d = eval_taken;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (flush || rsp_rdy) begin
                    state_d = ST_IDLE;
                    taken_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                taken_d = 1'b0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q  <= 4'b0000;
            cnt_q   <= CNT_ZERO;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
            cond_q  <= 4'b0000;
            taken_q <= 1'b0;
        end else begin
            nzcv_q  <= nzcv_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            state_q <= state_d;
            cond_q  <= cond_d;
            taken_q <= taken_d;
        end
    end

    assign req_rdy   = (state_q == ST_IDLE);
    assign rsp_vld   = (state_q == ST_RESP);
    assign rsp_taken = taken_q;
    assign nzcv      = nzcv_q;
    assign pend_err  = err_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: condition table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_flag_cond_unit;

    localparam int PEND_W  = 2;
    localparam int CNT_MAX = (1 << PEND_W) - 1;
`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, flush, fset_issue, flag_wr;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       req_vld, req_rdy, rsp_vld, rsp_rdy, rsp_taken, pend_err;
    logic [3:0] req_cond, nzcv;

    int errors = 0;
    int checks = 0;

    flag_cond_unit #(.PEND_W(PEND_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fset_issue(fset_issue),
        .flag_wr(flag_wr), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
        .alu_v(alu_v), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_cond(req_cond), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_taken(rsp_taken), .nzcv(nzcv), .pend_err(pend_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       exp;
    } vec_t;
    vec_t vecs[21];

    int         m_cnt;
    logic [3:0] m_nzcv, m_cond;
    logic       m_err, m_wait, m_resp, m_taken;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; fset_issue = 1'b0; flag_wr = 1'b0;
        {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
        req_vld = 1'b0; req_cond = 4'd0; rsp_rdy = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Architectural meaning: base test on cond[3:1], odd codes invert it.
    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return c[0] ? !base : base;
    endfunction

    // Put flags into NZCV through a legal issue/write pair (count ends at 0).
    task automatic set_flags(input logic [3:0] f);
        fset_issue = 1'b1;
        tick();
        fset_issue = 1'b0;
        flag_wr = 1'b1;
        {alu_n, alu_z, alu_c, alu_v} = f;
        tick();
        flag_wr = 1'b0;
    endtask

    // Issue one request and wait (bounded) for its response; no ack.
    task automatic run_req(input string name, input logic [3:0] c, output int lat);
        req_vld = 1'b1;
        req_cond = c;
        tick();
        req_vld = 1'b0;
        lat = 1;
        while (!rsp_vld && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_rsp_seen"}, rsp_vld, 1'b1);
    endtask

    task automatic ack();
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0] alu;
        logic fwd_ok;
        int n_cnt;
        logic [3:0] n_nzcv, n_cond;
        logic n_err, n_wait, n_resp, n_taken;

        vecs[0]  = '{4'd0,  4'b0100, 1'b1};
        vecs[1]  = '{4'd1,  4'b0100, 1'b0};
        vecs[2]  = '{4'd2,  4'b0010, 1'b1};
        vecs[3]  = '{4'd3,  4'b0010, 1'b0};
        vecs[4]  = '{4'd4,  4'b1000, 1'b1};
        vecs[5]  = '{4'd5,  4'b1000, 1'b0};
        vecs[6]  = '{4'd6,  4'b0000, 1'b0};
        vecs[7]  = '{4'd7,  4'b0000, 1'b1};
        vecs[8]  = '{4'd8,  4'b0010, 1'b1};
        vecs[9]  = '{4'd8,  4'b0110, 1'b0};
        vecs[10] = '{4'd9,  4'b0110, 1'b1};
        vecs[11] = '{4'd9,  4'b0010, 1'b0};
        vecs[12] = '{4'd10, 4'b1001, 1'b1};
        vecs[13] = '{4'd11, 4'b1001, 1'b0};
        vecs[14] = '{4'd11, 4'b1000, 1'b1};
        vecs[15] = '{4'd12, 4'b0000, 1'b1};
        vecs[16] = '{4'd12, 4'b0100, 1'b0};
        vecs[17] = '{4'd13, 4'b0001, 1'b1};
        vecs[18] = '{4'd13, 4'b0000, 1'b0};
        vecs[19] = '{4'd14, 4'b0000, 1'b1};
        vecs[20] = '{4'd15, 4'b1111, 1'b1};

        do_reset();
        chk("rst_nzcv", nzcv, 4'b0000);
        chk("rst_req_rdy", req_rdy, 1'b1);
        chk("rst_rsp_vld", rsp_vld, 1'b0);
        chk("rst_rsp_taken", rsp_taken, 1'b0);
        chk("rst_pend_err", pend_err, 1'b0);

        // EQ at count 0 with flags 0000: one-cycle response, not taken.
        req_vld = 1'b1; req_cond = 4'd0;
        tick();
        req_vld = 1'b0;
        chk("eq0_rsp_vld", rsp_vld, 1'b1);
        chk("eq0_taken", rsp_taken, 1'b0);
        chk("eq0_req_rdy_busy", req_rdy, 1'b0);
        ack();
        chk("eq0_back_idle", req_rdy, 1'b1);
        chk("eq0_rsp_dropped", rsp_vld, 1'b0);

        // GT waits behind two flag-setters; the second write decides.
        fset_issue = 1'b1;
        tick();
        tick();
        fset_issue = 1'b0;
        req_vld = 1'b1; req_cond = 4'd12;
        tick();
        req_vld = 1'b0;
        chk("gt_wait_rdy", req_rdy, 1'b0);
        chk("gt_wait_vld", rsp_vld, 1'b0);
        flag_wr = 1'b1; {alu_n, alu_z, alu_c, alu_v} = 4'b0010;
        tick();
        chk("gt_wait_after_wr1", rsp_vld, 1'b0);
        {alu_n, alu_z, alu_c, alu_v} = 4'b1001;
        tick();
        flag_wr = 1'b0;
        chk("gt_fwd_edge", rsp_vld, FWD);
        if (!FWD) tick();
        chk("gt_rsp_vld", rsp_vld, 1'b1);
        chk("gt_taken", rsp_taken, 1'b1);
        chk("gt_nzcv", nzcv, 4'b1001);
        ack();

        // LT with the only outstanding flag write in the request cycle.
        fset_issue = 1'b1;
        tick();
        fset_issue = 1'b0;
        req_vld = 1'b1; req_cond = 4'd11;
        flag_wr = 1'b1; {alu_n, alu_z, alu_c, alu_v} = 4'b1000;
        tick();
        req_vld = 1'b0; flag_wr = 1'b0;
        chk("lt_fwd_edge", rsp_vld, FWD);
        if (!FWD) tick();
        chk("lt_rsp_vld", rsp_vld, 1'b1);
        chk("lt_taken", rsp_taken, 1'b1);
        ack();

        // Back-pressure: response held stable, new request refused.
        set_flags(4'b0100);
        run_req("hold", 4'd0, lat);
        chk("hold_lat", lat, 1);
        req_vld = 1'b1; req_cond = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_vld", rsp_vld, 1'b1);
            chk("hold_taken", rsp_taken, 1'b1);
            chk("hold_rdy", req_rdy, 1'b0);
        end
        req_vld = 1'b0;
        ack();
        chk("hold_released", rsp_vld, 1'b0);
        tick();
        chk("hold_no_extra_rsp", rsp_vld, 1'b0);

        // Counter saturation at 3, then underflow with flags still latched.
        fset_issue = 1'b1;
        tick(); tick(); tick();
        chk("sat_no_err_yet", pend_err, 1'b0);
        tick();
        fset_issue = 1'b0;
        chk("sat_err", pend_err, 1'b1);
        flag_wr = 1'b1; {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
        tick(); tick(); tick();
        flag_wr = 1'b0;
        run_req("sat_drained", 4'd0, lat);
        chk("sat_drained_lat", lat, 1);
        chk("sat_drained_taken", rsp_taken, 1'b0);
        ack();
        flag_wr = 1'b1; {alu_n, alu_z, alu_c, alu_v} = 4'b1111;
        tick();
        flag_wr = 1'b0;
        chk("uf_err_sticky", pend_err, 1'b1);
        chk("uf_nzcv", nzcv, 4'b1111);

        do_reset();
        flag_wr = 1'b1; {alu_n, alu_z, alu_c, alu_v} = 4'b0101;
        tick();
        flag_wr = 1'b0;
        chk("uf_fresh_err", pend_err, 1'b1);
        chk("uf_fresh_nzcv", nzcv, 4'b0101);

        // Flush while waiting: no response, counter cleared.
        do_reset();
        fset_issue = 1'b1;
        tick();
        fset_issue = 1'b0;
        req_vld = 1'b1; req_cond = 4'd0;
        tick();
        req_vld = 1'b0;
        chk("flush_waiting", req_rdy, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_rdy", req_rdy, 1'b1);
        chk("flush_no_rsp", rsp_vld, 1'b0);
        tick(); tick();
        chk("flush_still_no_rsp", rsp_vld, 1'b0);
        run_req("flush_cnt0", 4'd14, lat);
        chk("flush_cnt0_lat", lat, 1);
        ack();

        // Asynchronous reset in the middle of a response.
        set_flags(4'b0100);
        run_req("arst", 4'd0, lat);
        chk("arst_pre_taken", rsp_taken, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp_vld", rsp_vld, 1'b0);
        chk("arst_taken", rsp_taken, 1'b0);
        chk("arst_nzcv", nzcv, 4'b0000);
        chk("arst_err", pend_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_rdy", req_rdy, 1'b1);

        // Condition table through the architectural register.
        for (int i = 0; i < 21; i++) begin
            set_flags(vecs[i].flags);
            run_req("tbl", vecs[i].cond, lat);
            chk($sformatf("tbl%0d_taken", i), rsp_taken, vecs[i].exp);
            chk($sformatf("tbl%0d_lat", i), lat, 1);
            ack();
        end

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_cnt = 0; m_nzcv = 4'b0000; m_cond = 4'b0000;
        m_err = 1'b0; m_wait = 1'b0; m_resp = 1'b0; m_taken = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            fset_issue = ($urandom_range(0, 3) == 0);
            flag_wr    = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            req_vld    = $urandom_range(0, 1) == 1;
            rsp_rdy    = $urandom_range(0, 2) == 0;
            req_cond   = 4'($urandom_range(0, 15));
            {alu_n, alu_z, alu_c, alu_v} = 4'($urandom_range(0, 15));
            alu = {alu_n, alu_z, alu_c, alu_v};
            fwd_ok = FWD && (m_cnt == 1) && flag_wr && !fset_issue;

            n_cnt = m_cnt; n_nzcv = m_nzcv; n_err = m_err;
            n_wait = m_wait; n_resp = m_resp; n_taken = m_taken; n_cond = m_cond;
            if (flag_wr) n_nzcv = alu;
            if (flush) n_cnt = 0;
            else if (fset_issue && !flag_wr) begin
                if (m_cnt == CNT_MAX) n_err = 1'b1; else n_cnt = m_cnt + 1;
            end else if (flag_wr && !fset_issue) begin
                if (m_cnt == 0) n_err = 1'b1; else n_cnt = m_cnt - 1;
            end
            if (flush) begin
                n_wait = 1'b0; n_resp = 1'b0;
            end else if (m_resp) begin
                if (rsp_rdy) n_resp = 1'b0;
            end else if (m_wait) begin
                if (m_cnt == 0) begin
                    n_wait = 1'b0; n_resp = 1'b1; n_taken = ref_eval(m_cond, m_nzcv);
                end else if (fwd_ok) begin
                    n_wait = 1'b0; n_resp = 1'b1; n_taken = ref_eval(m_cond, alu);
                end
            end else if (req_vld) begin
                n_cond = req_cond;
                if (m_cnt == 0) begin
                    n_resp = 1'b1; n_taken = ref_eval(req_cond, m_nzcv);
                end else if (fwd_ok) begin
                    n_resp = 1'b1; n_taken = ref_eval(req_cond, alu);
                end else begin
                    n_wait = 1'b1;
                end
            end

            tick();
            m_cnt = n_cnt; m_nzcv = n_nzcv; m_err = n_err;
            m_wait = n_wait; m_resp = n_resp; m_taken = n_taken; m_cond = n_cond;

            chk("rnd_req_rdy", req_rdy, !(m_wait || m_resp));
            chk("rnd_rsp_vld", rsp_vld, m_resp);
            if (m_resp) chk("rnd_taken", rsp_taken, m_taken);
            chk("rnd_nzcv", nzcv, m_nzcv);
            chk("rnd_pend_err", pend_err, m_err);
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
